frame_read_requester: RTL and testbench

Read-side counterpart of the pixel-to-phrase write path. It walks a frame buffer in DDR by issuing 128-bit read commands to the MIG user interface and buffers the returned phrases. It then presents them as an AXI-Stream of 128-bit phrases, with `tuser_out` marking the first phrase of each frame, ready for the phrase-to-word digester. Outstanding reads are credit-limited so MIG read data, which cannot be back-pressured, is never lost.

---
 rtl/mig_pkg.sv | 23 ++
 rtl/phrase_fifo.sv | 62 ++++++
 rtl/frame_read_requester.sv | 153 +++++++++++++++
 tb/tb_frame_read_requester.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_pkg.sv
// Shared MIG command codes, read-requester state encoding and a wrapping
// counter helper used by the frame read path.
package mig_pkg;

  localparam logic [2:0] MIG_CMD_READ  = 3'b001;
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // addr_increment pattern: advance a counter by one, returning to zero
  // when it reaches the limit.
  function automatic logic [31:0] wrap_inc(input logic [31:0] value,
                                           input logic [31:0] limit);
    logic [31:0] nxt;
    nxt = value + 32'd1;
    return (nxt >= limit) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/phrase_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head. The caller is
// responsible for never pushing into a full FIFO unless it pops in the same
// cycle, and never popping an empty one.
module phrase_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic do_pop;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr_reg];

  // Storage write; contents need no reset because the head is only used
  // while the FIFO is non-empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/frame_read_requester.sv
// Walks a DDR frame buffer with MIG read commands and re-emits the returned
// phrases as an AXI-Stream, tagging the first phrase of each frame. Reads in
// flight plus phrases still buffered are limited by a credit count so the
// non-back-pressurable MIG read data always has a FIFO slot.
module frame_read_requester
  import mig_pkg::*;
#(
  parameter int unsigned FRAME_PHRASES   = 9600,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int unsigned ADDR_STRIDE     = 8,
  parameter int          ADDR_W          = 27,
  parameter int          MAX_OUTSTANDING = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  input  logic [127:0]      app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [127:0]      data_out,
  output logic              tuser_out,
  output logic              frame_done_out,
  output logic              busy_out,
  output logic              error_out
);

  localparam int CRED_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IDX_W  = (FRAME_PHRASES > 1) ? $clog2(FRAME_PHRASES) : 1;

  rd_state_t         state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [IDX_W-1:0]  cmd_idx_reg;
  logic [IDX_W-1:0]  rx_idx_reg;
  logic [CRED_W-1:0] credits_reg;
  logic              frame_done_reg;
  logic              error_reg;

  logic         cmd_accept;
  logic         last_cmd;
  logic         out_fire;
  logic         rd_expected;
  logic         fifo_push;
  logic         fifo_empty;
  logic         fifo_full;
  logic [128:0] fifo_head;

  assign app_en      = (state_reg == ISSUE) &&
                       (credits_reg < CRED_W'(MAX_OUTSTANDING));
  assign cmd_accept  = app_en && app_rdy;
  assign last_cmd    = (cmd_idx_reg == IDX_W'(FRAME_PHRASES - 1));
  assign out_fire    = valid_out && ready_out;
  assign rd_expected = app_rd_data_valid && (credits_reg != '0);
  // The credit limit keeps the FIFO from ever being full on a legal push;
  // the full guard only protects storage against a misbehaving MIG.
  assign fifo_push   = rd_expected && (!fifo_full || out_fire);

  assign app_addr       = addr_reg;
  assign app_cmd        = MIG_CMD_READ;
  assign frame_done_out = frame_done_reg;
  assign busy_out       = (state_reg != IDLE);
  assign error_out      = error_reg;

  assign valid_out = !fifo_empty;
  assign data_out  = valid_out ? fifo_head[127:0] : '0;
  assign tuser_out = valid_out && fifo_head[128];

  // Command-side FSM: state, address walk, frame index and frame-done pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      addr_reg       <= ADDR_W'(BASE_ADDR);
      cmd_idx_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable_in) begin
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_accept) begin
            cmd_idx_reg <= IDX_W'(wrap_inc(32'(cmd_idx_reg), 32'(FRAME_PHRASES)));
            if (last_cmd) begin
              addr_reg       <= ADDR_W'(BASE_ADDR);
              frame_done_reg <= 1'b1;
              if (!enable_in) begin
                state_reg <= DRAIN;
              end
            end else begin
              addr_reg <= addr_reg + ADDR_W'(ADDR_STRIDE);
            end
          end
        end
        DRAIN: begin
          if (credits_reg == '0) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Credits: one per read issued, returned when its phrase leaves the stream.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      credits_reg <= '0;
    end else begin
      case ({cmd_accept, out_fire})
        2'b10:   credits_reg <= credits_reg + 1'b1;
        2'b01:   credits_reg <= credits_reg - 1'b1;
        default: credits_reg <= credits_reg;
      endcase
    end
  end

  // Response index (for frame-start tagging) and sticky unexpected-data flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_idx_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      if (fifo_push) begin
        rx_idx_reg <= IDX_W'(wrap_inc(32'(rx_idx_reg), 32'(FRAME_PHRASES)));
      end
      if (app_rd_data_valid && (credits_reg == '0)) begin
        error_reg <= 1'b1;
      end
    end
  end

  phrase_fifo #(
    .WIDTH (129),
    .DEPTH (MAX_OUTSTANDING)
  ) u_phrase_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data ({(rx_idx_reg == '0), app_rd_data}),
    .pop       (out_fire),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_frame_read_requester.sv
// Randomized bench for frame_read_requester: a MIG model with fixed read
// latency, a queue-based model of the expected phrase stream, and checks on
// addresses, frame tagging, credit stalls, hold behaviour, error and reset.
module tb_frame_read_requester;

  localparam int unsigned FP     = 4;
  localparam int unsigned BASE   = 32'h100;
  localparam int unsigned STRIDE = 8;
  localparam int          AW     = 27;
  localparam int unsigned MAXO   = 4;
  localparam int unsigned LAT    = 5;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          enable_in;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [127:0]  app_rd_data;
  logic          app_rd_data_valid;
  logic          valid_out;
  logic          ready_out;
  logic [127:0]  data_out;
  logic          tuser_out;
  logic          frame_done_out;
  logic          busy_out;
  logic          error_out;

  frame_read_requester #(
    .FRAME_PHRASES   (FP),
    .BASE_ADDR       (BASE),
    .ADDR_STRIDE     (STRIDE),
    .ADDR_W          (AW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .enable_in         (enable_in),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .valid_out         (valid_out),
    .ready_out         (ready_out),
    .data_out          (data_out),
    .tuser_out         (tuser_out),
    .frame_done_out    (frame_done_out),
    .busy_out          (busy_out),
    .error_out         (error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned  due;
    logic [127:0] data;
  } mig_t;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  mig_t        mig_q[$];
  logic [128:0] exp_q[$];
  int unsigned n_cmd = 0;
  int unsigned n_out = 0;
  int unsigned outstanding = 0;
  int unsigned fifo_level = 0;
  int unsigned fd_count = 0;
  logic        err_exp = 1'b0;
  logic        fd_exp = 1'b0;
  int          rdy_mode = 0;
  int          rdy_out_mode = 0;
  logic        spur_req = 1'b0;

  logic          prev_hold = 1'b0;
  logic [127:0]  prev_data = '0;
  logic          prev_tuser = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // MIG read-data model and randomized handshake drivers.
  always @(posedge clk_in) begin
    #1;
    cyc++;
    app_rd_data_valid = 1'b0;
    if (!rst_in) begin
      if (mig_q.size() > 0 && mig_q[0].due <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = mig_q[0].data;
        void'(mig_q.pop_front());
      end else if (spur_req && mig_q.size() == 0) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
        spur_req          = 1'b0;
      end
    end
    case (rdy_mode)
      0:       app_rdy = 1'b1;
      1:       app_rdy = ~app_rdy;
      default: app_rdy = 1'($urandom_range(0, 1));
    endcase
    case (rdy_out_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = 1'b0;
      default: ready_out = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk_in) begin : monitor
    logic          acc;
    logic [127:0]  d;
    logic [128:0]  e;
    logic [AW-1:0] exp_addr;
    int unsigned   out_pre;
    if (rst_in) begin
      prev_hold  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      out_pre = outstanding;
      check("frame_done", frame_done_out, fd_exp);
      check("valid_out", valid_out, fifo_level > 0);
      check("error_out", error_out, err_exp);
      if (frame_done_out) fd_count++;
      if (outstanding == MAXO) check("en_at_full", app_en, 0);
      if (prev_hold) begin
        check("hold_data", data_out, prev_data);
        check("hold_tuser", tuser_out, prev_tuser);
      end
      if (prev_stall) check("addr_hold", app_addr, prev_addr);

      acc    = app_en && app_rdy;
      fd_exp = acc && (n_cmd % FP == FP - 1);
      if (acc) begin
        exp_addr = AW'(BASE + (n_cmd % FP) * STRIDE);
        check("cmd_addr", app_addr, exp_addr);
        d = {$urandom, $urandom, $urandom, $urandom};
        mig_q.push_back('{due: cyc + LAT, data: d});
        exp_q.push_back({(n_cmd % FP == 0), d});
        $display("cmd  %0d addr %h", n_cmd, app_addr);
        n_cmd++;
        outstanding++;
      end
      if (valid_out && ready_out && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", data_out, e[127:0]);
        check("out_tuser", tuser_out, e[128]);
        $display("out  %0d tuser %0b data %h", n_out, tuser_out, data_out);
        n_out++;
        outstanding--;
        if (fifo_level > 0) fifo_level--;
      end
      if (app_rd_data_valid) begin
        if (out_pre == 0) err_exp = 1'b1;
        else fifo_level++;
      end
      prev_hold  = valid_out && !ready_out;
      prev_data  = data_out;
      prev_tuser = tuser_out;
      prev_stall = app_en && !app_rdy;
      prev_addr  = app_addr;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic pulse_enable();
    enable_in = 1'b1;
    cycles(1);
    enable_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycles(1);
      if (i > 3 && outstanding == 0 && exp_q.size() == 0 && !busy_out) break;
    end
    check("idle_busy", busy_out, 0);
    check("drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_app_en", app_en, 0);
    check("rst_app_addr", app_addr, AW'(BASE));
    check("rst_app_cmd", app_cmd, 3'b001);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_tuser", tuser_out, 0);
    check("rst_frame_done", frame_done_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_error", error_out, 0);
  endtask

  task automatic clear_model();
    mig_q.delete();
    exp_q.delete();
    n_cmd       = 0;
    outstanding = 0;
    fifo_level  = 0;
    err_exp     = 1'b0;
    fd_exp      = 1'b0;
  endtask

  initial begin : main
    int unsigned base;
    int unsigned fd0;
    rst_in      = 1'b1;
    enable_in   = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    app_rdy     = 1'b1;
    ready_out   = 1'b1;
    cycles(3);
    check_reset_values();
    rst_in = 1'b0;
    cycles(2);

    // Single frame with everything ready.
    fd0 = fd_count;
    pulse_enable();
    wait_idle(200);
    check("s1_cmds", n_cmd, 4);
    check("s1_outs", n_out, 4);
    check("s1_frame_done", fd_count - fd0, 1);

    // Downstream stalled: credits cap the reads at MAXO.
    base = n_cmd;
    rdy_out_mode = 1;
    cycles(1);
    enable_in = 1'b1;
    cycles(30);
    check("s2_cmds", n_cmd - base, MAXO);
    check("s2_app_en", app_en, 0);
    enable_in = 1'b0;
    rdy_out_mode = 0;
    wait_idle(200);

    // Three back-to-back frames.
    base = n_cmd;
    enable_in = 1'b1;
    for (int i = 0; i < 300 && (n_cmd - base) < 10; i++) cycles(1);
    enable_in = 1'b0;
    wait_idle(300);
    check("s3_cmds", n_cmd - base, 12);

    // app_rdy toggling every cycle.
    base = n_cmd;
    rdy_mode = 1;
    pulse_enable();
    wait_idle(300);
    rdy_mode = 0;
    check("s4_cmds", n_cmd - base, 4);

    // Spurious read data while idle.
    base = n_out;
    spur_req = 1'b1;
    cycles(10);
    check("s5_error", error_out, 1);
    check("s5_no_output", n_out - base, 0);
    cycles(5);
    check("s5_error_sticky", error_out, 1);

    // Reset after two of four commands.
    base = n_cmd;
    pulse_enable();
    for (int i = 0; i < 100 && (n_cmd - base) < 2; i++) @(negedge clk_in);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    clear_model();
    #1;
    check_reset_values();
    cycles(2);
    rst_in = 1'b0;
    cycles(1);
    pulse_enable();
    wait_idle(200);
    check("s6_cmds", n_cmd, 4);

    // Randomized handshakes over several frames.
    rdy_mode = 2;
    rdy_out_mode = 2;
    enable_in = 1'b1;
    cycles(int'($urandom_range(20, 60)));
    enable_in = 1'b0;
    wait_idle(1000);
    check("s7_frame_aligned", n_cmd % FP, 0);
    rdy_mode = 0;
    rdy_out_mode = 0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
